muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers, alongside the single-cycle ALU in EX.

---
 rtl/muldiv_unit_pkg.sv | 32 +++
 rtl/muldiv_iter_core.sv | 41 ++++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants, state encoding and operation decode helpers for the
// iterative multiply/divide unit.
package muldiv_unit_pkg;

   localparam int WORD_WIDTH_DEFAULT = 32;

   // Operation select codes; every other code is treated as "no operation".
   localparam logic [2:0] MDOP_MULT  = 3'b001;
   localparam logic [2:0] MDOP_MULTU = 3'b010;
   localparam logic [2:0] MDOP_DIV   = 3'b011;
   localparam logic [2:0] MDOP_DIVU  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic op_valid(input logic [2:0] op);
      return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
             (op == MDOP_DIV)  || (op == MDOP_DIVU);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MDOP_DIV) || (op == MDOP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == MDOP_MULT) || (op == MDOP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Single iteration of the multiply/divide datapath on a 2W-bit accumulator.
// Multiply: the low half holds the not-yet-consumed multiplier bits and the
// high half the running partial product (shift-add, LSB first).
// Divide: the high half is the partial remainder and quotient bits are shifted
// into the low half (restoring shift-subtract).
module muldiv_iter_core #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                    is_div,
   input  logic [2*WORD_WIDTH-1:0] acc,
   input  logic [WORD_WIDTH-1:0]   operand,
   output logic [2*WORD_WIDTH-1:0] acc_next
);

   logic [WORD_WIDTH:0]   sum;
   logic [WORD_WIDTH:0]   partial;
   logic [WORD_WIDTH-1:0] diff;
   logic                  fits;

   // One step: the shifted partial remainder can carry one bit past W, so the
   // trial subtract compares on W+1 bits; the difference itself always fits W.
   always_comb begin
      sum      = {1'b0, acc[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, operand};
      partial  = acc[2*WORD_WIDTH-1:WORD_WIDTH-1];
      diff     = partial[WORD_WIDTH-1:0] - operand;
      fits     = (partial >= {1'b0, operand});
      acc_next = acc;
      if (is_div) begin
         if (fits) begin
            acc_next = {diff, acc[WORD_WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {partial[WORD_WIDTH-1:0], acc[WORD_WIDTH-2:0], 1'b0};
         end
      end else if (acc[0]) begin
         acc_next = {sum, acc[WORD_WIDTH-1:1]};
      end else begin
         acc_next = {1'b0, acc[2*WORD_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at launch, iterated for WORD_WIDTH cycles,
// then signs and special cases are applied in a single FIX cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            MDOp,
   input  logic [WORD_WIDTH-1:0] inA,
   input  logic [WORD_WIDTH-1:0] inB,
   input  logic                  cancel,
   input  logic                  mthi,
   input  logic                  mtlo,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] hi,
   output logic [WORD_WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORD_WIDTH - 1);

   md_state_e state;
   md_state_e state_next;

   logic [CNT_W-1:0]        count;
   logic [2*WORD_WIDTH-1:0] acc;
   logic [2*WORD_WIDTH-1:0] acc_next;
   logic [WORD_WIDTH-1:0]   operand;
   logic [WORD_WIDTH-1:0]   dividend_raw;
   logic                    is_div;
   logic                    neg_res;
   logic                    neg_rem;
   logic                    div_zero;

   logic                    start_ok;
   logic                    a_neg;
   logic                    b_neg;
   logic [WORD_WIDTH-1:0]   a_mag;
   logic [WORD_WIDTH-1:0]   b_mag;

   logic [2*WORD_WIDTH-1:0] prod_fix;
   logic [WORD_WIDTH-1:0]   quot;
   logic [WORD_WIDTH-1:0]   rem;
   logic [WORD_WIDTH-1:0]   res_hi;
   logic [WORD_WIDTH-1:0]   res_lo;

   assign busy = (state != ST_IDLE);

   muldiv_iter_core #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_core (
      .is_div   (is_div),
      .acc      (acc),
      .operand  (operand),
      .acc_next (acc_next)
   );

   // Launch decode: accept only in IDLE with a valid op; signed ops use magnitudes.
   always_comb begin
      start_ok = (state == ST_IDLE) && start && op_valid(MDOp);
      a_neg    = op_is_signed(MDOp) && inA[WORD_WIDTH-1];
      b_neg    = op_is_signed(MDOp) && inB[WORD_WIDTH-1];
      a_mag    = a_neg ? (~inA + 1'b1) : inA;
      b_mag    = b_neg ? (~inB + 1'b1) : inB;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; cancel beats both the last CALC step and FIX completion.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            if (cancel) begin
               state_next = ST_IDLE;
            end else if (count == LAST_COUNT) begin
               state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand latch at launch, then one datapath step per CALC cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         acc          <= '0;
         operand      <= '0;
         dividend_raw <= '0;
         is_div       <= 1'b0;
         neg_res      <= 1'b0;
         neg_rem      <= 1'b0;
         div_zero     <= 1'b0;
      end else if (start_ok) begin
         count        <= '0;
         acc          <= op_is_div(MDOp) ? {{WORD_WIDTH{1'b0}}, a_mag}
                                         : {{WORD_WIDTH{1'b0}}, b_mag};
         operand      <= op_is_div(MDOp) ? b_mag : a_mag;
         dividend_raw <= inA;
         is_div       <= op_is_div(MDOp);
         neg_res      <= a_neg ^ b_neg;
         neg_rem      <= a_neg;
         div_zero     <= (inB == '0);
      end else if ((state == ST_CALC) && !cancel) begin
         acc   <= acc_next;
         count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
      end else begin
         count <= '0;
      end
   end

   // Sign fix-up and special cases; division by zero overrides the iterated result.
   always_comb begin
      prod_fix = neg_res ? (~acc + 1'b1) : acc;
      quot     = acc[WORD_WIDTH-1:0];
      rem      = acc[2*WORD_WIDTH-1:WORD_WIDTH];
      if (neg_res) begin
         quot = ~quot + 1'b1;
      end
      if (neg_rem) begin
         rem = ~rem + 1'b1;
      end
      if (div_zero) begin
         quot = '1;
         rem  = dividend_raw;
      end
      res_hi = is_div ? rem  : prod_fix[2*WORD_WIDTH-1:WORD_WIDTH];
      res_lo = is_div ? quot : prod_fix[WORD_WIDTH-1:0];
   end

   // HI/LO and done: results land on the FIX edge; mt* writes only when idle and not launching.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == ST_FIX) && !cancel;
         if ((state == ST_FIX) && !cancel) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if ((state == ST_IDLE) && !start_ok) begin
            if (mthi) begin
               hi <= wdata;
            end
            if (mtlo) begin
               lo <= wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WORD_WIDTH=32.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   md_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         cancel;
   logic         mthi;
   logic         mtlo;
   logic [W-1:0] wdata;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int compare_count  = 0;
   int mismatch_count = 0;

   vec_t vecs [9];

   muldiv_unit #(
      .WORD_WIDTH(W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .MDOp   (md_op),
      .inA    (in_a),
      .inB    (in_b),
      .cancel (cancel),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case the stimulus itself gets stuck.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present an op for exactly one rising edge; called from a negedge.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
      start = 1'b1;
      md_op = op;
      in_a  = a;
      in_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until done is seen at a negedge; note any cycle with busy low before it.
   task automatic waitDone(output int edges, output logic busy_dropped);
      edges        = 0;
      busy_dropped = 1'b0;
      while (edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (done) return;
         if (!busy) busy_dropped = 1'b1;
      end
   endtask

   // Watch a window of cycles and count done pulses.
   task automatic countDone(input int cycles, output int pulses);
      pulses = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
   endtask

   int   edges;
   int   pulses;
   logic busy_dropped;

   initial begin
      vecs[0] = '{MDOP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1] = '{MDOP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{MDOP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[3] = '{MDOP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[4] = '{MDOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{MDOP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[6] = '{MDOP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[7] = '{MDOP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[8] = '{MDOP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

      rst    = 1'b1;
      start  = 1'b0;
      md_op  = 3'b000;
      in_a   = '0;
      in_b   = '0;
      cancel = 1'b0;
      mthi   = 1'b0;
      mtlo   = 1'b0;
      wdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_hi",   hi,   32'h0);
      checkOutput("reset_lo",   lo,   32'h0);
      checkOutput("reset_busy", W'(busy), 32'h0);
      checkOutput("reset_done", W'(done), 32'h0);

      // Table-driven ops: latency, busy throughout, result, one-cycle done.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitDone(edges, busy_dropped);
         checkOutput($sformatf("v%0d_latency", i), W'(edges), 32'd33);
         checkOutput($sformatf("v%0d_busy_held", i), W'(busy_dropped), 32'h0);
         checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
         checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
         @(negedge clk);
         checkOutput($sformatf("v%0d_done_width", i), W'(done), 32'h0);
      end

      // MULTU, then DIV launched in the done cycle with no bubble.
      applyStimulus(MDOP_MULTU, 32'hFFFFFFFF, 32'h00000002);
      waitDone(edges, busy_dropped);
      checkOutput("multu_hi", hi, 32'h00000001);
      checkOutput("multu_lo", lo, 32'hFFFFFFFE);
      applyStimulus(MDOP_DIV, 32'hFFFFFFF9, 32'h00000002);
      waitDone(edges, busy_dropped);
      checkOutput("b2b_latency", W'(edges), 32'd33);
      checkOutput("b2b_busy_held", W'(busy_dropped), 32'h0);
      checkOutput("b2b_div_lo", lo, 32'hFFFFFFFD);
      checkOutput("b2b_div_hi", hi, 32'hFFFFFFFF);

      // DIVU by zero with an mthi attempt while busy.
      @(negedge clk);
      applyStimulus(MDOP_DIVU, 32'h00000007, 32'h00000000);
      @(negedge clk);
      mthi  = 1'b1;
      wdata = 32'h00001234;
      @(negedge clk);
      mthi  = 1'b0;
      waitDone(edges, busy_dropped);
      checkOutput("divu0_done", W'(done), 32'h1);
      checkOutput("divu0_lo", lo, 32'hFFFFFFFF);
      checkOutput("divu0_hi", hi, 32'h00000007);

      // Cancel at cycle 10: no done, HI/LO keep the DIVU-by-zero result.
      @(negedge clk);
      applyStimulus(MDOP_MULTU, 32'h00000003, 32'h00000005);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      @(negedge clk);
      checkOutput("cancel_busy", W'(busy), 32'h0);
      checkOutput("cancel_hi", hi, 32'h00000007);
      checkOutput("cancel_lo", lo, 32'hFFFFFFFF);
      countDone(40, pulses);
      checkOutput("cancel_no_done", W'(pulses), 32'h0);

      // Reset at cycle 10 mid-op.
      applyStimulus(MDOP_MULTU, 32'h00000003, 32'h00000005);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_mid_busy", W'(busy), 32'h0);
      checkOutput("rst_mid_hi", hi, 32'h0);
      checkOutput("rst_mid_lo", lo, 32'h0);
      countDone(40, pulses);
      checkOutput("rst_mid_no_done", W'(pulses), 32'h0);

      // Simultaneous mthi/mtlo in IDLE.
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'hA5A5A5A5;
      @(negedge clk);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      checkOutput("mt_both_hi", hi, 32'hA5A5A5A5);
      checkOutput("mt_both_lo", lo, 32'hA5A5A5A5);

      // start + mtlo together: start wins; then a start during busy is ignored.
      mtlo  = 1'b1;
      wdata = 32'hDEADBEEF;
      applyStimulus(MDOP_MULTU, 32'h00000006, 32'h00000007);
      mtlo  = 1'b0;
      @(negedge clk);
      checkOutput("start_mtlo_dropped", lo, 32'hA5A5A5A5);
      start = 1'b1;
      md_op = MDOP_DIVU;
      in_a  = 32'd100;
      in_b  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      waitDone(edges, busy_dropped);
      checkOutput("busy_start_latency", W'(edges), 32'd32);
      checkOutput("start_mtlo_hi", hi, 32'h0);
      checkOutput("start_mtlo_lo", lo, 32'd42);
      @(negedge clk);
      checkOutput("busy_start_no_relaunch", W'(busy), 32'h0);

      // Invalid op codes never leave IDLE.
      applyStimulus(3'b000, 32'd5, 32'd5);
      @(negedge clk);
      checkOutput("invalid_000_busy", W'(busy), 32'h0);
      applyStimulus(3'b111, 32'd5, 32'd5);
      @(negedge clk);
      checkOutput("invalid_111_busy", W'(busy), 32'h0);
      checkOutput("invalid_lo", lo, 32'd42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
